// File: rtl/mmio_bridge.sv
// Single-master MMIO bridge: decodes a CPU load/store onto one of NSLV slave
// windows, inserts per-slave wait states and returns aligned, extended data.
module mmio_bridge #(
  parameter int                 NSLV          = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE      = {32'h7f50, 32'h7f60, 32'h7f00, 32'h0},
  parameter logic [NSLV*32-1:0] SLV_LIMIT     = {32'h7f57, 32'h7f73, 32'h7f0b, 32'h2fff},
  parameter logic [NSLV*4-1:0]  SLV_WAIT      = {4'd0, 4'd0, 4'd0, 4'd1},
  parameter logic [NSLV-1:0]    SLV_WORD_ONLY = 4'b0100,
  parameter logic [NSLV-1:0]    SLV_RO        = 4'b0000,
  parameter logic [4:0]         EXC_ADEL      = 5'd4,
  parameter logic [4:0]         EXC_ADES      = 5'd5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic [4:0]         resp_exc,
  output logic [NSLV-1:0]    s_sel,
  output logic               s_we,
  output logic [3:0]         s_byteen,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  input  logic [NSLV*32-1:0] s_rdata
);

  // state     | meaning
  // ST_IDLE   | ready for a request, decode on acceptance
  // ST_ACCESS | first slave cycle, write strobe for stores
  // ST_WAIT   | extra wait-state cycles until count == W
  // ST_RESP   | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;

  state_t state_q, state_d;

  logic [3:0]      cnt_q, wait_q;
  logic [NSLV-1:0] sel_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [1:0]      size_q;
  logic            signed_q, write_q;
  logic [3:0]      be_q;
  logic [4:0]      exc_q;

  logic            hit, hit_wo, hit_ro;
  logic [NSLV-1:0] hit_oh;
  logic [3:0]      hit_wait;
  logic            misaligned, exc_any, accept, active, last;
  logic [3:0]      be_d;
  logic [31:0]     wrep_d, rd_mux, rd_ext;

  // Walk downward so the lowest matching window is the one that sticks.
  always_comb begin
    hit      = 1'b0;
    hit_oh   = '0;
    hit_wait = 4'd0;
    hit_wo   = 1'b0;
    hit_ro   = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (req_addr >= SLV_BASE[32*i +: 32] && req_addr <= SLV_LIMIT[32*i +: 32]) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_wait  = SLV_WAIT[4*i +: 4];
        hit_wo    = SLV_WORD_ONLY[i];
        hit_ro    = SLV_RO[i];
      end
    end
  end

  always_comb begin
    misaligned = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'd0);
    exc_any    = 1'b0;
    if (misaligned)                  exc_any = 1'b1;
    else if (!hit)                   exc_any = 1'b1;
    else if (hit_wo && !req_size[1]) exc_any = 1'b1;
    else if (hit_ro && req_write)    exc_any = 1'b1;
  end

  always_comb begin
    be_d   = 4'b1111;
    wrep_d = req_wdata;
    case (req_size)
      2'd0: begin
        be_d   = 4'b0001 << req_addr[1:0];
        wrep_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_d   = req_addr[1] ? 4'b1100 : 4'b0011;
        wrep_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < NSLV; i++)
      if (sel_q[i]) rd_mux = rd_mux | s_rdata[32*i +: 32];
  end

  always_comb begin
    rd_ext = rd_mux;
    case (size_q)
      2'd0: begin
        logic [7:0] b;
        b      = 8'(rd_mux >> {addr_q[1:0], 3'b000});
        rd_ext = signed_q ? {{24{b[7]}}, b} : {24'd0, b};
      end
      2'd1: begin
        logic [15:0] h;
        h      = addr_q[1] ? rd_mux[31:16] : rd_mux[15:0];
        rd_ext = signed_q ? {{16{h[15]}}, h} : {16'd0, h};
      end
      default: ;
    endcase
  end

  assign accept = req_valid && (state_q == ST_IDLE);
  assign active = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
  assign last   = active && (cnt_q == wait_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:             if (accept) state_d = exc_any ? ST_RESP : ST_ACCESS;
      ST_ACCESS, ST_WAIT:  state_d = last ? ST_RESP : ST_WAIT;
      ST_RESP:             state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      wait_q   <= 4'd0;
      sel_q    <= '0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      be_q     <= 4'd0;
      exc_q    <= 5'd0;
    end else if (accept) begin
      cnt_q    <= 4'd0;
      wait_q   <= hit_wait;
      sel_q    <= exc_any ? '0 : hit_oh;
      addr_q   <= req_addr;
      wdata_q  <= wrep_d;
      rdata_q  <= 32'd0;
      size_q   <= req_size;
      signed_q <= req_signed;
      write_q  <= req_write;
      be_q     <= be_d;
      exc_q    <= exc_any ? (req_write ? EXC_ADES : EXC_ADEL) : 5'd0;
    end else if (last) begin
      rdata_q <= write_q ? 32'd0 : rd_ext;
    end else if (active) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_exc   = (state_q == ST_RESP) ? exc_q : 5'd0;
    resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;
    s_sel      = active ? sel_q : '0;
    s_we       = (state_q == ST_ACCESS) && write_q;
    s_byteen   = ((state_q == ST_ACCESS) && write_q) ? be_q : 4'd0;
    s_addr     = addr_q;
    s_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: expected responses are queued at issue and
// checked when resp_valid appears, alongside slave-side strobe observations.
module tb_mmio_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_write, req_signed;
  logic [1:0]   req_size;
  logic [31:0]  req_addr, req_wdata;
  logic         req_ready, resp_valid, s_we;
  logic [31:0]  resp_rdata, s_addr, s_wdata;
  logic [4:0]   resp_exc;
  logic [3:0]   s_sel, s_byteen;
  logic [127:0] s_rdata;

  localparam logic [127:0] RD_GOOD = {32'h80FF1234, 32'h55667788, 32'h11223344, 32'h8899AABB};

  always #5 clk = ~clk;

  mmio_bridge #(
    .SLV_WORD_ONLY(4'b0110),
    .SLV_RO       (4'b0110)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .s_sel(s_sel), .s_we(s_we), .s_byteen(s_byteen),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  exc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int          sel_cnt, we_cnt, be_cnt, rdy_cnt, addr_bad, lat_seen;
  logic [3:0]  first_sel, we_be;
  logic [31:0] we_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic [4:0] exp_exc,
                        input int exp_lat, input logic hold);
    exp_t e;
    exp_t got;
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    e.rdata = exp_rd; e.exc = exp_exc; e.lat = exp_lat;
    sb_q.push_back(e);
    sel_cnt = 0; we_cnt = 0; be_cnt = 0; rdy_cnt = 0; addr_bad = 0; lat_seen = 0;
    first_sel = 4'd0; we_be = 4'd0; we_data = 32'd0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (hold) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 32'h0000_0100; req_wdata = 32'hFFFF_FFFF;
      end else begin
        req_valid = 1'b0;
      end
      if (s_sel != 4'd0) begin
        if (sel_cnt == 0) first_sel = s_sel;
        sel_cnt++;
        if (s_addr !== addr) addr_bad++;
      end
      if (s_we) begin we_cnt++; we_be = s_byteen; we_data = s_wdata; end
      if (s_byteen != 4'd0) be_cnt++;
      if (req_ready) rdy_cnt++;
      // Garbage on slave 0 during its first (non-final) cycle exposes early sampling.
      s_rdata = RD_GOOD;
      if (s_sel[0] && sel_cnt == 1) s_rdata[31:0] = 32'hDEAD_BEEF;
      if (resp_valid) begin lat_seen = k; break; end
    end
    req_valid = 1'b0;
    s_rdata = RD_GOOD;
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk({tag, " rdata"},   resp_rdata,        got.rdata);
      chk({tag, " exc"},     32'(resp_exc),     32'(got.exc));
      chk({tag, " latency"}, 32'(lat_seen),     32'(got.lat));
      chk({tag, " sel_cyc"}, 32'(sel_cnt),      (got.exc != 5'd0) ? 32'd0 : 32'(got.lat - 1));
      chk({tag, " we_cyc"},  32'(we_cnt),       (wr && got.exc == 5'd0) ? 32'd1 : 32'd0);
      chk({tag, " be_cyc"},  32'(be_cnt),       (wr && got.exc == 5'd0) ? 32'd1 : 32'd0);
      chk({tag, " busy_rdy"}, 32'(rdy_cnt),     32'd0);
      chk({tag, " s_addr"},  32'(addr_bad),     32'd0);
    end
    @(negedge clk);
    chk({tag, " pulse_end"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; s_rdata = RD_GOOD;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst ready",  32'(req_ready),  32'd1);
    chk("rst rvalid", 32'(resp_valid), 32'd0);
    chk("rst sel",    32'(s_sel),      32'd0);
    chk("rst we_be",  {27'd0, s_we, s_byteen}, 32'd0);
    chk("rst resp",   resp_rdata | 32'(resp_exc), 32'd0);

    do_req("lw_s0",   1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'd0, 32'h8899AABB, 5'd0, 3, 1'b0);
    chk("lw_s0 sel", 32'(first_sel), 32'b0001);
    do_req("lb_s3",   1'b0, 2'd0, 1'b1, 32'h0000_7f53, 32'd0, 32'hFFFFFF80, 5'd0, 2, 1'b0);
    chk("lb_s3 sel", 32'(first_sel), 32'b1000);
    do_req("lhu_s3",  1'b0, 2'd1, 1'b0, 32'h0000_7f52, 32'd0, 32'h000080FF, 5'd0, 2, 1'b0);
    do_req("lh_pos",  1'b0, 2'd1, 1'b1, 32'h0000_7f50, 32'd0, 32'h00001234, 5'd0, 2, 1'b0);
    do_req("lh_neg",  1'b0, 2'd1, 1'b1, 32'h0000_7f52, 32'd0, 32'hFFFF80FF, 5'd0, 2, 1'b0);
    do_req("lbu_lim", 1'b0, 2'd0, 1'b0, 32'h0000_7f57, 32'd0, 32'h00000080, 5'd0, 2, 1'b0);
    do_req("lb_b1",   1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'd0, 32'hFFFFFFAA, 5'd0, 3, 1'b0);

    do_req("sb_s0",   1'b1, 2'd0, 1'b0, 32'h0000_0002, 32'h000000A5, 32'd0, 5'd0, 3, 1'b0);
    chk("sb_s0 be",    32'(we_be), 32'b0100);
    chk("sb_s0 wdata", we_data,    32'hA5A5A5A5);
    do_req("sh_s0",   1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h1234BEEF, 32'd0, 5'd0, 3, 1'b0);
    chk("sh_s0 be",    32'(we_be), 32'b1100);
    chk("sh_s0 wdata", we_data,    32'hBEEFBEEF);
    do_req("sw_s3",   1'b1, 2'd2, 1'b0, 32'h0000_7f54, 32'h12345678, 32'd0, 5'd0, 2, 1'b0);
    chk("sw_s3 be",    32'(we_be), 32'b1111);
    chk("sw_s3 wdata", we_data,    32'h12345678);
    chk("sw_s3 sel",   32'(first_sel), 32'b1000);

    do_req("sh_wo",    1'b1, 2'd1, 1'b0, 32'h0000_7f00, 32'h1, 32'd0, 5'd5, 1, 1'b0);
    do_req("lb_wo",    1'b0, 2'd0, 1'b0, 32'h0000_7f00, 32'd0, 32'd0, 5'd4, 1, 1'b0);
    do_req("lw_unmap", 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, 32'd0, 5'd4, 1, 1'b0);
    do_req("lw_mis",   1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0, 32'd0, 5'd4, 1, 1'b0);
    do_req("lh_mis",   1'b0, 2'd1, 1'b0, 32'h0000_7f51, 32'd0, 32'd0, 5'd4, 1, 1'b0);
    do_req("sw_ro",    1'b1, 2'd2, 1'b0, 32'h0000_7f70, 32'h5, 32'd0, 5'd5, 1, 1'b0);
    do_req("sw_misun", 1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'h5, 32'd0, 5'd5, 1, 1'b0);
    do_req("lw_pastl", 1'b0, 2'd2, 1'b0, 32'h0000_7f0c, 32'd0, 32'd0, 5'd4, 1, 1'b0);
    do_req("lb_below", 1'b0, 2'd0, 1'b0, 32'h0000_7f4f, 32'd0, 32'd0, 5'd4, 1, 1'b0);

    do_req("lw_s1",    1'b0, 2'd2, 1'b0, 32'h0000_7f04, 32'd0, 32'h11223344, 5'd0, 2, 1'b0);
    chk("lw_s1 sel", 32'(first_sel), 32'b0010);
    do_req("lw_lim0",  1'b0, 2'd2, 1'b0, 32'h0000_2ffc, 32'd0, 32'h8899AABB, 5'd0, 3, 1'b0);
    do_req("lw_hold",  1'b0, 2'd2, 1'b0, 32'h0000_7f60, 32'd0, 32'h55667788, 5'd0, 2, 1'b1);
    chk("lw_hold sel", 32'(first_sel), 32'b0100);

    // Abort a slave-0 load while it sits in its wait state.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort access", 32'(s_sel), 32'b0001);
    @(negedge clk);
    chk("abort wait", 32'(s_sel), 32'b0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort ready",  32'(req_ready),  32'd1);
    chk("abort rvalid", 32'(resp_valid), 32'd0);
    chk("abort sel",    32'(s_sel),      32'd0);
    begin
      int stray = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (resp_valid || s_sel != 4'd0 || s_we) stray++;
      end
      chk("abort stray", 32'(stray), 32'd0);
    end

    do_req("lw_after", 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0, 32'h8899AABB, 5'd0, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
